// File: rtl/controller.sv
// Instruction-cycle sequencer for a simple accumulator CPU: walks eight
// phases per instruction and decodes the datapath control strobes.
module controller (
   input  logic       clk,
   input  logic       rst_,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       data_e,
   output logic       wr,
   output logic       halt,
   output logic [2:0] phase
);

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_HLT = 3'd0;
   localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
   localparam logic [OP_W-1:0] OP_ADD = 3'd2;
   localparam logic [OP_W-1:0] OP_AND = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR = 3'd4;
   localparam logic [OP_W-1:0] OP_LDA = 3'd5;
   localparam logic [OP_W-1:0] OP_STO = 3'd6;
   localparam logic [OP_W-1:0] OP_JMP = 3'd7;

   typedef enum logic [OP_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   phase_e r_phase;
   logic   r_halted;
   phase_e w_phase_nxt;
   logic   w_halted_nxt;
   logic   w_aluop;

   assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

   assign phase = 3'(r_phase);

   // Phase and halted-flag registers; reset is asynchronous.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_phase  <= INST_ADDR;
         r_halted <= 1'b0;
      end else begin
         r_phase  <= w_phase_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   // Next-phase sequencing and combinational control decode.
   always_comb begin
      w_phase_nxt  = r_phase;
      w_halted_nxt = r_halted;
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      data_e = 1'b0;
      wr     = 1'b0;
      halt   = 1'b0;

      if (r_halted) begin
         // Frozen in OP_ADDR until reset; only halt is asserted.
         halt = 1'b1;
      end else begin
         if ((r_phase == OP_ADDR) && (opcode == OP_HLT)) begin
            w_halted_nxt = 1'b1;
         end else begin
            w_phase_nxt = phase_e'(3'(r_phase + 3'd1));
         end

         case (r_phase)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            OP_FETCH: begin
               rd = w_aluop;
            end
            ALU_OP: begin
               rd     = w_aluop;
               ld_ac  = w_aluop;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            STORE: begin
               rd     = w_aluop;
               ld_ac  = w_aluop;
               inc_pc = (opcode == OP_JMP);
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
               wr     = (opcode == OP_STO);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller.sv
// Randomized bench for controller against a phase-table reference model.
module tb_controller;

   logic       clk;
   logic       rst_;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
   logic [2:0] phase;

   int n_checks;
   int n_fail;

   // Reference state: instruction phase and halted flag.
   int m_phase;
   bit m_halted;

   controller dut (
      .clk    (clk),
      .rst_   (rst_),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .data_e (data_e),
      .wr     (wr),
      .halt   (halt),
      .phase  (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h (phase_model=%0d halted=%0d op=%0d z=%0d t=%0t)",
                  tag, obs, exp, m_phase, m_halted, opcode, zero, $time);
      end
   endtask

   // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt} from the phase table.
   function automatic logic [8:0] exp_outs(input int ph, input logic [2:0] op,
                                           input logic z, input bit hlt);
      bit aluop;
      logic [8:0] v;
      if (hlt) return 9'b0_0000_0001;
      aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      v[8] = (ph <= 3);
      v[7] = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && aluop);
      v[6] = (ph == 2) || (ph == 3);
      v[5] = (ph == 4) || ((ph == 6) && (op == 3'd1) && z) || ((ph == 7) && (op == 3'd7));
      v[4] = (ph >= 6) && (op == 3'd7);
      v[3] = (ph >= 6) && aluop;
      v[2] = (ph >= 6) && (op == 3'd6);
      v[1] = (ph == 7) && (op == 3'd6);
      v[0] = (ph == 4) && (op == 3'd0);
      return v;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_outs"}, 32'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}),
          32'(exp_outs(m_phase, opcode, zero, m_halted)));
      chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
   endtask

   // One clock cycle: advance model at the edge, drive new inputs, check;
   // optionally pulse reset mid-cycle and check before and after release.
   task automatic step(input logic [2:0] op, input logic z, input bit do_rst, input string tag);
      @(posedge clk);
      if (rst_) begin
         if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
         end
      end
      #1;
      opcode = op;
      zero   = z;
      #1;
      check_all(tag);
      if (do_rst) begin
         rst_ = 1'b0;
         #1;
         m_phase  = 0;
         m_halted = 1'b0;
         check_all({tag, "_rst"});
         rst_ = 1'b1;
         #1;
         check_all({tag, "_rel"});
      end
   endtask

   logic [2:0] r_op;
   int         halt_cycles;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_phase  = 0;
      m_halted = 1'b0;
      rst_     = 1'b0;
      opcode   = 3'd6;
      zero     = 1'b1;
      #2;
      check_all("reset");
      #10;
      check_all("reset_hold");
      rst_ = 1'b1;

      // ADD, SKZ (zero=1 / zero=0 / zero toggled outside phase 6), JMP.
      for (int i = 0; i < 8; i++) step(3'd2, 1'b0, 1'b0, "add");
      for (int i = 0; i < 8; i++) step(3'd1, 1'b1, 1'b0, "skz_z1");
      for (int i = 0; i < 8; i++) step(3'd1, 1'b0, 1'b0, "skz_z0");
      for (int i = 0; i < 8; i++) step(3'd1, (m_phase == 4), 1'b0, "skz_tog");
      for (int i = 0; i < 8; i++) step(3'd7, 1'b0, 1'b0, "jmp");

      // STO, then async reset while in phase 7 with STO.
      for (int i = 0; i < 7; i++) step(3'd6, 1'b0, 1'b0, "sto");
      chk("sto_ph7_wr", 32'(wr), 32'(m_phase == 7));
      step(3'd6, 1'b0, 1'b1, "sto_rst");
      step(3'd6, 1'b0, 1'b0, "post_rst");

      // HLT: run until halted, hold 25 cycles with random inputs, then reset.
      for (int i = 0; i < 6; i++) step(3'd0, 1'b0, 1'b0, "hlt");
      chk("hlt_flag", 32'(m_halted), 32'(1));
      for (int i = 0; i < 25; i++)
         step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, "halted");
      chk("halted_phase", 32'(phase), 32'(4));
      step(3'd3, 1'b0, 1'b1, "hlt_rst");
      step(3'd3, 1'b0, 1'b0, "hlt_post");

      // Random traffic; HLT is rare, and a halt is cleared after a while.
      halt_cycles = 0;
      for (int i = 0; i < 2500; i++) begin
         r_op = 3'($urandom_range(0, 7));
         if (r_op == 3'd0 && $urandom_range(0, 5) != 0) r_op = 3'($urandom_range(1, 7));
         halt_cycles = m_halted ? halt_cycles + 1 : 0;
         step(r_op, 1'($urandom_range(0, 1)),
              (halt_cycles > 22) || ($urandom_range(0, 59) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_  input  1  asynchronous, active-low reset; asserting it takes effect immediately, independent of clk.
REQ-004 opcode  input  3  current instruction opcode from the instruction register: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-005 zero  input  1  accumulator-is-zero flag from the ALU.
REQ-006 sel  output  1  address mux select: 1 selects the PC address, 0 selects the IR operand address; drives sel_a of the downstream address mux.
REQ-007 rd  output  1  memory read enable.
REQ-008 ld_ir  output  1  instruction register load.
REQ-009 inc_pc  output  1  program counter increment.
REQ-010 ld_pc  output  1  program counter load from the IR operand.
REQ-011 ld_ac  output  1  accumulator load.
REQ-012 data_e  output  1  data bus drive enable for stores.
REQ-013 wr  output  1  memory write enable.
REQ-014 halt  output  1  processor halted indication.
REQ-015 phase  output  3  current instruction phase, for debug and verification.

Function
REQ-016 The block SHALL sequence an 8-phase instruction cycle: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-017 When not halted, the phase SHALL advance by 1 on every rising clk edge and wrap from 7 to 0; there are no stall inputs.
REQ-018 Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-019 All outputs except halt SHALL be combinational decodes of (phase, opcode, zero, halted); there is no output register latency.
REQ-020 sel SHALL be 1 in phases 0-3 and 0 in phases 4-7.
REQ-021 rd SHALL be 1 in phases 1-3, and in phases 5-7 when ALUOP.
REQ-022 ld_ir SHALL be 1 in phases 2-3 only.
REQ-023 inc_pc SHALL be 1:
  - in phase 4;
  - in phase 6 when opcode=SKZ and zero=1;
  - in phase 7 when opcode=JMP.
REQ-024 ld_pc SHALL be 1 in phases 6-7 when opcode=JMP.
REQ-025 ld_ac SHALL be 1 in phases 6-7 when ALUOP.
REQ-026 data_e SHALL be 1 in phases 6-7 when opcode=STO.
REQ-027 wr SHALL be 1 in phase 7 only, when opcode=STO.
REQ-028 In phase 4, halt SHALL be 1 combinationally when opcode=HLT.
REQ-029 On the clk edge ending a phase-4 cycle with opcode=HLT, the internal halted flag SHALL set, and phase SHALL hold at 4.
REQ-030 While halted:
  - phase SHALL remain 4;
  - halt SHALL be 1;
  - every other output SHALL be 0;
  - opcode and zero changes SHALL be ignored;
  - only reset SHALL clear halted.
REQ-031 zero SHALL be sampled only in phase 6; its value in any other phase SHALL have no effect.
REQ-032 Opcodes that would hold an output outside the phases listed above SHALL NOT produce that output; no output SHALL ever be X for known inputs.

Reset
REQ-033 While rst_=0, the block SHALL set phase=0 and halted=0; outputs SHALL read sel=1 and all others 0.
REQ-034 Assertion of rst_ mid-instruction (any phase, or while halted) SHALL take effect without waiting for a clk edge.
REQ-035 After rst_ deasserts, the first rising clk edge SHALL advance phase to 1.

Verification
REQ-036 Reset: assert rst_=0 asynchronously during phase 7 with opcode=STO -> wr and data_e drop at once; phase=0, sel=1; next edge after release gives phase=1.
REQ-037 ADD (opcode=2), 8 cycles -> sel=1 in phases 0-3; rd=1 in phases 1-3 and 5-7; ld_ir=1 in phases 2-3; inc_pc=1 in phase 4 only; ld_ac=1 in phases 6-7; wr=0 throughout.
REQ-038 SKZ (opcode=1) -> with zero=1, inc_pc=1 in phases 4 and 6; with zero=0, inc_pc=1 in phase 4 only; zero toggled in phase 5 has no effect.
REQ-039 STO (opcode=6) -> data_e=1 in phases 6-7; wr=1 in phase 7 only; rd=0 and ld_ac=0 in phases 5-7.
REQ-040 JMP (opcode=7) -> ld_pc=1 in phases 6-7; inc_pc=1 in phases 4 and 7.
REQ-041 HLT (opcode=0) -> halt=1 in phase 4; phase then stays 4 for 20+ cycles with halt=1 and all other outputs 0, under any opcode; rst_ pulse returns phase to 0 with halt=0.
